// File: rtl/regfile_pkg.sv
// Shared types and default widths for the multi-port register file.
package regfile_pkg;

  typedef enum logic [0:0] {
    RF_IDLE  = 1'b0,
    RF_SWEEP = 1'b1
  } rf_state_e;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;

endpackage

// File: rtl/regfile_sweep_ctrl.sv
// Clear-sweep controller: walks every address once, writing zero, then idles.
module regfile_sweep_ctrl
  import regfile_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clr_req,
  output logic              ready,
  output logic              sweep_we,
  output logic [ADDR_W-1:0] sweep_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  rf_state_e         state;
  logic [ADDR_W-1:0] ptr;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= RF_SWEEP;
      ptr   <= '0;
    end else begin
      case (state)
        RF_SWEEP: begin
          ptr <= ptr + ADDR_W'(1);
          if (ptr == LAST_ADDR) state <= RF_IDLE;
        end
        RF_IDLE: begin
          // A clear request mid-sweep is not possible here: clr_req is only seen in IDLE.
          if (clr_req) begin
            state <= RF_SWEEP;
            ptr   <= '0;
          end
        end
        default: begin
          state <= RF_SWEEP;
          ptr   <= '0;
        end
      endcase
    end
  end

  assign ready      = (state == RF_IDLE);
  assign sweep_we   = (state == RF_SWEEP);
  assign sweep_addr = ptr;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with sweep-based clear and a combinational debug port.
// Optional write-to-read forwarding is compiled in with `define REGFILE_BYPASS_EN.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     clr_req,
  output logic                     ready,
  input  logic [ADDR_W-1:0]        dbg_addr,
  output logic [DATA_W-1:0]        dbg_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              sweep_we;
  logic [ADDR_W-1:0] sweep_addr;
  logic              wr_fire;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  regfile_sweep_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_sweep (
    .clock      (clock),
    .reset      (reset),
    .clr_req    (clr_req),
    .ready      (ready),
    .sweep_we   (sweep_we),
    .sweep_addr (sweep_addr)
  );

  // User writes are only accepted in IDLE; register 0 is write-protected when hardwired.
  assign wr_fire = ready && wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

  // Single write port: the sweep owns it while clearing, the user port otherwise.
  assign mem_we    = sweep_we || wr_fire;
  assign mem_addr  = sweep_we ? sweep_addr : wr_addr;
  assign mem_wdata = sweep_we ? '0 : wr_data;

  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  assign dbg_data = mem[dbg_addr];

  // ---- read stage p0 -> p1 ----
  for (genvar k = 0; k < NUM_RD; k++) begin : g_lane
    logic [ADDR_W-1:0] addr_p0;
    logic [DATA_W-1:0] data_p1;

    assign addr_p0 = rd_addr[k*ADDR_W +: ADDR_W];

    always_ff @(posedge clock) begin
      if (!reset || !ready) begin
        data_p1 <= '0;
      end else if ((ZERO_REG != 0) && (addr_p0 == '0)) begin
        data_p1 <= '0;
`ifdef REGFILE_BYPASS_EN
      end else if (wr_fire && (wr_addr == addr_p0)) begin
        data_p1 <= wr_data;
`endif
      end else begin
        data_p1 <= mem[addr_p0];
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = data_p1;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus random traffic against a cycle model.
module tb_regfile_mp;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic                     clock = 1'b0;
  logic                     reset;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     clr_req;
  logic                     ready;
  logic [ADDR_W-1:0]        dbg_addr;
  logic [DATA_W-1:0]        dbg_data;

  always #5 clock = ~clock;

  regfile_mp #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (1)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .clr_req  (clr_req),
    .ready    (ready),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // Reference model: register contents, remaining clear cycles, expected lane outputs.
  logic [DATA_W-1:0] mem_m  [DEPTH];
  logic [DATA_W-1:0] exp_rd [NUM_RD];
  logic [ADDR_W-1:0] ra     [NUM_RD];
  int busy = DEPTH;
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [DATA_W-1:0] lane(input int k);
    return rd_data[k*DATA_W +: DATA_W];
  endfunction

  // Advance one clock: predict from current inputs, then compare after the edge.
  task automatic tick();
    bit fire;
    for (int k = 0; k < NUM_RD; k++) rd_addr[k*ADDR_W +: ADDR_W] = ra[k];
    if (!reset) begin
      busy = DEPTH;
      for (int k = 0; k < NUM_RD; k++) exp_rd[k] = '0;
    end else if (busy > 0) begin
      mem_m[DEPTH-busy] = '0;
      busy--;
      for (int k = 0; k < NUM_RD; k++) exp_rd[k] = '0;
    end else begin
      fire = wr_en && (wr_addr != 0);
      for (int k = 0; k < NUM_RD; k++) begin
        if (ra[k] == 0) exp_rd[k] = '0;
`ifdef REGFILE_BYPASS_EN
        else if (fire && wr_addr == ra[k]) exp_rd[k] = wr_data;
`endif
        else exp_rd[k] = mem_m[ra[k]];
      end
      if (fire) mem_m[wr_addr] = wr_data;
      if (clr_req) busy = DEPTH;
    end
    @(posedge clock);
    #1;
    check("ready", {31'b0, ready}, (busy == 0) ? 32'd1 : 32'd0);
    for (int k = 0; k < NUM_RD; k++) check($sformatf("rd_lane%0d", k), lane(k), exp_rd[k]);
    if (busy == 0) check("dbg_data", dbg_data, mem_m[dbg_addr]);
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; clr_req = 1'b0; dbg_addr = '0;
    for (int k = 0; k < NUM_RD; k++) ra[k] = '0;
  endtask

  initial begin
    reset = 1'b0;
    rd_addr = '0;
    idle_inputs();

    // Reset then clear sweep: ready low exactly DEPTH cycles after release.
    tick(); tick();
    reset = 1'b1;
    for (int i = 0; i < DEPTH - 1; i++) tick();
    check("ready_before_end", {31'b0, ready}, 32'd0);
    tick();
    check("ready_after_sweep", {31'b0, ready}, 32'd1);

    // Basic write/read on both lanes.
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEADBEEF; tick();
    wr_en = 1'b0; ra[0] = 5'd7; ra[1] = 5'd7; tick();
    check("r7_lane0", lane(0), 32'hDEADBEEF);
    check("r7_lane1", lane(1), 32'hDEADBEEF);

    // Zero register write is discarded.
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678; ra[0] = 5'd7; ra[1] = 5'd7; tick();
    wr_en = 1'b0; ra[0] = 5'd0; ra[1] = 5'd0; dbg_addr = 5'd0; tick();
    check("r0_lane0", lane(0), 32'h0);
    check("r0_dbg", dbg_data, 32'h0);

    // Same-cycle write and read of r3.
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h1; tick();
    wr_data = 32'hA5A5A5A5; ra[0] = 5'd3; ra[1] = 5'd3; dbg_addr = 5'd3; tick();
`ifdef REGFILE_BYPASS_EN
    check("r3_same_cycle", lane(0), 32'hA5A5A5A5);
`else
    check("r3_same_cycle", lane(0), 32'h1);
`endif
    wr_en = 1'b0; tick();
    check("r3_after", lane(1), 32'hA5A5A5A5);

    // clr_req together with a write to r9; writes during the sweep are ignored.
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h55; clr_req = 1'b1; ra[0] = 5'd9; tick();
    clr_req = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      wr_en = 1'b1; wr_addr = 5'($urandom_range(1, DEPTH-1)); wr_data = $urandom;
      tick();
    end
    wr_en = 1'b0; ra[0] = 5'd9; ra[1] = 5'd7; dbg_addr = 5'd9; tick();
    check("r9_cleared", lane(0), 32'h0);
    check("r9_dbg_cleared", dbg_data, 32'h0);

    // Reset at sweep cycle 10 restarts the sweep.
    clr_req = 1'b1; tick();
    clr_req = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b0; tick();
    reset = 1'b1;
    for (int i = 0; i < DEPTH - 1; i++) tick();
    check("restart_ready_low", {31'b0, ready}, 32'd0);
    tick();
    check("restart_ready_high", {31'b0, ready}, 32'd1);

    // Random traffic with occasional clears and resets.
    for (int i = 0; i < 600; i++) begin
      reset    = ($urandom_range(0, 199) != 0);
      clr_req  = ($urandom_range(0, 59) == 0);
      wr_en    = ($urandom_range(0, 2) != 0);
      wr_addr  = 5'($urandom_range(0, 7));
      wr_data  = $urandom;
      dbg_addr = 5'($urandom_range(0, 7));
      for (int k = 0; k < NUM_RD; k++) ra[k] = 5'($urandom_range(0, 7));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
